// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C gain master: controller state encoding,
// SCL phase numbering within one bit slot, and the default slave address.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_REG,
        ST_REG_ACK,
        ST_DATA,
        ST_DATA_ACK,
        ST_STOP
    } state_t;

    // Four quarter-period phases of every SCL bit slot.
    localparam logic [1:0] PH0 = 2'd0;  // SCL low, SDA updated on entry
    localparam logic [1:0] PH1 = 2'd1;  // SCL low
    localparam logic [1:0] PH2 = 2'd2;  // SCL high, ACK sampled on last cycle
    localparam logic [1:0] PH3 = 2'd3;  // SCL high

    localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h6A;

endpackage

// File: rtl/i2c_bit_timer.sv
// Quarter-period timer for the I2C master.
// Ports:
//   clk, rst      - system clock, asynchronous active-high reset
//   en_i          - run the timer; when low, counters are cleared to phase 0
//   hold_i        - freeze the timer in its current phase (master stall)
//   phase_tick_o  - high on the last clk cycle of the current phase
//   phase_o       - current phase 0..3
module i2c_bit_timer #(
    parameter int unsigned CLK_DIV = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic       hold_i,
    output logic       phase_tick_o,
    output logic [1:0] phase_o
);

    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    phase_q, phase_d;

    always_comb begin
        phase_tick_o = en_i && !hold_i && (cnt_q == LAST);
        cnt_d        = cnt_q;
        phase_d      = phase_q;
        if (!en_i) begin
            cnt_d   = '0;
            phase_d = '0;
        end else if (!hold_i) begin
            if (phase_tick_o) begin
                cnt_d   = '0;
                phase_d = phase_q + 2'd1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase_o = phase_q;

endmodule

// File: rtl/i2c_gain_master.sv
// I2C write master for the equalizer gain registers.
// Sends START, {SLAVE_ADDR,W}, register pointer, byte_count data bytes, STOP.
// Ports:
//   clk, rst              - system clock, asynchronous active-high reset
//   start                 - one-cycle request, honoured only in IDLE
//   start_addr/byte_count - register pointer and data byte count (latched)
//   data_in/data_valid    - data source; data_ready marks the accept window
//   busy, done, ack_error - transaction status (ack_error is sticky)
//   scl, sda              - I2C bus; sda released during ACK slots
module i2c_gain_master
    import i2c_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR = DEFAULT_SLAVE_ADDR,
    parameter int unsigned CLK_DIV    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] start_addr,
    input  logic [3:0] byte_count,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       busy,
    output logic       done,
    output logic       ack_error,
    output logic       scl,
    inout  wire        sda
);

    state_t     state_q, state_d;
    logic [7:0] reg_q, reg_d;
    logic [3:0] bytes_q, bytes_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_q, bit_d;
    logic       loaded_q, loaded_d;     // data byte captured for the next DATA slot
    logic       ack_err_q, ack_err_d;
    logic       stop_last_q, stop_last_d; // second pass of STOP: SDA high tail
    logic       done_q, done_d;

    logic       tick, hold, is_ack, slot_end;
    logic [1:0] phase;
    logic       sda_oe, sda_out;

    i2c_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk          (clk),
        .rst          (rst),
        .en_i         (state_q != ST_IDLE),
        .hold_i       (hold),
        .phase_tick_o (tick),
        .phase_o      (phase)
    );

    // Stall SCL low in P0 until the next data byte has been captured.
    assign hold     = (state_q == ST_DATA) && !loaded_q;
    assign is_ack   = (state_q == ST_ADDR_ACK) || (state_q == ST_REG_ACK) ||
                      (state_q == ST_DATA_ACK);
    assign slot_end = tick && (phase == PH3);

    always_comb begin
        state_d     = state_q;
        reg_d       = reg_q;
        bytes_d     = bytes_q;
        shift_d     = shift_q;
        bit_d       = bit_q;
        loaded_d    = loaded_q;
        ack_err_d   = ack_err_q;
        stop_last_d = stop_last_q;
        done_d      = 1'b0;

        data_ready = !loaded_q &&
                     ((state_q == ST_DATA) ||
                      (((state_q == ST_REG_ACK) || (state_q == ST_DATA_ACK)) &&
                       (phase == PH3) && (bytes_q != '0) && !ack_err_q));

        if (is_ack && tick && (phase == PH2) && (sda == 1'b1))
            ack_err_d = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_START;
                    reg_d       = start_addr;
                    bytes_d     = byte_count;
                    ack_err_d   = 1'b0;
                    loaded_d    = 1'b0;
                    stop_last_d = 1'b0;
                end
            end
            ST_START: begin
                if (slot_end) begin
                    state_d = ST_ADDR;
                    shift_d = {SLAVE_ADDR, 1'b0};
                    bit_d   = 3'd7;
                end
            end
            ST_ADDR, ST_REG, ST_DATA: begin
                if (slot_end) begin
                    shift_d = {shift_q[6:0], 1'b0};
                    bit_d   = bit_q - 3'd1;
                    if (bit_q == 3'd0) begin
                        if (state_q == ST_ADDR) begin
                            state_d = ST_ADDR_ACK;
                        end else if (state_q == ST_REG) begin
                            state_d = ST_REG_ACK;
                        end else begin
                            state_d  = ST_DATA_ACK;
                            bytes_d  = bytes_q - 4'd1;
                            loaded_d = 1'b0;
                        end
                    end
                end
            end
            ST_ADDR_ACK: begin
                if (slot_end) begin
                    if (ack_err_q) begin
                        state_d = ST_STOP;
                    end else begin
                        state_d = ST_REG;
                        shift_d = reg_q;
                        bit_d   = 3'd7;
                    end
                end
            end
            ST_REG_ACK, ST_DATA_ACK: begin
                if (slot_end) begin
                    bit_d = 3'd7;
                    if (ack_err_q || (bytes_q == '0))
                        state_d = ST_STOP;
                    else
                        state_d = ST_DATA;
                end
            end
            ST_STOP: begin
                // Five phases: P0 low/low, P1-P2 SCL high, P3 + tail P0 SDA high.
                if (tick) begin
                    if (!stop_last_q && (phase == PH3)) begin
                        stop_last_d = 1'b1;
                    end else if (stop_last_q && (phase == PH0)) begin
                        state_d     = ST_IDLE;
                        stop_last_d = 1'b0;
                        done_d      = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (data_ready && data_valid) begin
            shift_d  = data_in;
            loaded_d = 1'b1;
        end
    end

    always_comb begin
        scl     = 1'b1;
        sda_oe  = 1'b0;
        sda_out = 1'b1;
        unique case (state_q)
            ST_START: begin
                sda_oe  = 1'b1;
                sda_out = !phase[1];
            end
            ST_ADDR, ST_REG: begin
                scl     = phase[1];
                sda_oe  = 1'b1;
                sda_out = shift_q[7];
            end
            ST_DATA: begin
                scl     = phase[1];
                sda_oe  = loaded_q;
                sda_out = shift_q[7];
            end
            ST_ADDR_ACK, ST_REG_ACK, ST_DATA_ACK: scl = phase[1];
            ST_STOP: begin
                scl     = stop_last_q || (phase != PH0);
                sda_oe  = 1'b1;
                sda_out = stop_last_q || (phase == PH3);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            reg_q       <= '0;
            bytes_q     <= '0;
            shift_q     <= '0;
            bit_q       <= '0;
            loaded_q    <= 1'b0;
            ack_err_q   <= 1'b0;
            stop_last_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            reg_q       <= reg_d;
            bytes_q     <= bytes_d;
            shift_q     <= shift_d;
            bit_q       <= bit_d;
            loaded_q    <= loaded_d;
            ack_err_q   <= ack_err_d;
            stop_last_q <= stop_last_d;
            done_q      <= done_d;
        end
    end

    assign sda       = sda_oe ? sda_out : 1'bz;
    assign busy      = (state_q != ST_IDLE) || done_q;
    assign done      = done_q;
    assign ack_error = ack_err_q;

endmodule

// File: tb/tb_i2c_gain_master.sv
// Bench for i2c_gain_master: bus-level slave model decodes START/STOP and
// bytes, ACKs or NACKs per transaction, and checks bytes, handshakes and
// status against the expected transaction contents.
module tb_i2c_gain_master;

    localparam logic [6:0]  SA = 7'h6A;
    localparam int unsigned CD = 5;

    logic       clk = 1'b0;
    logic       rst, start, data_valid;
    logic [7:0] start_addr, data_in;
    logic [3:0] byte_count;
    logic       data_ready, busy, done, ack_error, scl;
    wire        sda;

    pullup (sda);

    int tests = 0;
    int fails = 0;

    // Expected transaction (written by the stimulus process only)
    logic [7:0] exp_bytes [0:17];
    logic [7:0] feed_data [0:15];
    int         feed_delay [0:15];
    int         exp_n = 0, nack_idx = -1, hs_exp = 0, hs_base = 0, trans_id = 0;

    // Bus monitor / slave state (written by the monitor process only)
    logic       prev_scl = 1'b1, prev_sda = 1'b1, ack_arm = 1'b0;
    logic [7:0] sh = '0;
    logic [7:0] obs_bytes [0:17];
    int         bitcnt = 0, byte_idx = 0, starts = 0, stops = 0;
    int         hs_total = 0, done_total = 0, max_low = 0, low_run = 0;

    // Slave releases SDA as soon as SCL falls after the ACK clock.
    logic slave_pull;
    assign slave_pull = ack_arm && !((bitcnt == 9) && !scl);
    assign sda = slave_pull ? 1'b0 : 1'bz;

    i2c_gain_master #(.SLAVE_ADDR(SA), .CLK_DIV(CD)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .byte_count (byte_count),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .busy       (busy),
        .done       (done),
        .ack_error  (ack_error),
        .scl        (scl),
        .sda        (sda)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: decode bus, act as slave, check per-cycle rules.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                prev_scl = 1'b1; prev_sda = 1'b1; ack_arm = 1'b0;
                bitcnt = 0; low_run = 0;
                continue;
            end
            if (!scl) low_run++;
            else begin
                if (low_run > max_low) max_low = low_run;
                low_run = 0;
            end
            if (prev_scl && scl && prev_sda && !sda) begin
                starts++; bitcnt = 0; byte_idx = 0; max_low = 0; ack_arm = 1'b0;
            end else if (prev_scl && scl && !prev_sda && sda) begin
                stops++; bitcnt = 0;
            end else if (!prev_scl && scl) begin
                if (bitcnt < 8) sh = {sh[6:0], sda};
                bitcnt++;
                if (bitcnt == 8) begin
                    if (byte_idx < exp_n) chk($sformatf("bus_byte%0d", byte_idx), sh, exp_bytes[byte_idx]);
                    else chk("bus_extra_byte", byte_idx, exp_n);
                    if (byte_idx < 18) obs_bytes[byte_idx] = sh;
                    byte_idx++;
                end
            end else if (prev_scl && !scl) begin
                if (bitcnt == 8) ack_arm = ((byte_idx - 1) != nack_idx);
                else if (bitcnt == 9) begin ack_arm = 1'b0; bitcnt = 0; end
            end
            if (data_ready) begin
                chk("data_ready_allowed", int'((hs_total - hs_base) < hs_exp), 1);
                if (data_valid) hs_total++;
            end
            if (done) begin
                done_total++;
                chk("busy_during_done", busy, 1);
            end
            prev_scl = scl;
            prev_sda = sda;
        end
    end

    // Data source with per-byte valid delay counted while data_ready is high.
    initial begin
        int f_tid = 0, f_idx = 0, f_wait = 0;
        bit f_pend = 0;
        data_valid = 1'b0;
        data_in    = '0;
        forever begin
            @(negedge clk);
            if (trans_id != f_tid) begin
                f_tid = trans_id; f_idx = 0; f_wait = 0; f_pend = 0; data_valid = 1'b0;
            end
            if (f_pend) begin
                f_idx++; f_wait = 0; f_pend = 0; data_valid = 1'b0;
            end
            if (f_idx < 16) begin
                data_in = feed_data[f_idx];
                if (!data_valid) begin
                    if (feed_delay[f_idx] == 0) data_valid = 1'b1;
                    else if (data_ready) begin
                        f_wait++;
                        if (f_wait >= feed_delay[f_idx]) data_valid = 1'b1;
                    end
                end
            end
            if (data_ready && data_valid) f_pend = 1;
        end
    end

    task automatic setup_txn(input logic [7:0] addr, input int cnt, input int nk);
        exp_bytes[0] = {SA, 1'b0};
        exp_bytes[1] = addr;
        for (int i = 0; i < 16; i++) exp_bytes[i + 2] = feed_data[i];
        exp_n    = (nk < 0) ? cnt + 2 : nk + 1;
        hs_exp   = (nk < 0) ? cnt : ((nk >= 2) ? nk - 1 : 0);
        nack_idx = nk;
        hs_base  = hs_total;
        trans_id++;
    endtask

    task automatic pulse_start(input logic [7:0] addr, input int cnt);
        @(negedge clk);
        start_addr = addr;
        byte_count = 4'(cnt);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_txn(input logic [7:0] addr, input int cnt, input int nk,
                           input bit second_start, input bit exp_stall);
        int st0, sp0, d0, n;
        st0 = starts; sp0 = stops; d0 = done_total;
        setup_txn(addr, cnt, nk);
        pulse_start(addr, cnt);
        chk("busy_after_start", busy, 1);
        if (second_start) begin
            repeat (60) @(negedge clk);
            start_addr = 8'h55; byte_count = 4'd9; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        n = 0;
        while (!done && n < 6000) begin @(negedge clk); n++; end
        chk("done_within_budget", int'(n < 6000), 1);
        repeat (20) @(negedge clk);
        #2;
        chk("done_pulses", done_total - d0, 1);
        chk("start_conditions", starts - st0, 1);
        chk("stop_conditions", stops - sp0, 1);
        chk("bytes_on_bus", byte_idx, exp_n);
        chk("handshakes", hs_total - hs_base, hs_exp);
        chk("ack_error", ack_error, int'(nk >= 0));
        chk("busy_after_done", busy, 0);
        if (exp_stall) chk("scl_stall_ge20", int'(max_low >= 20), 1);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 16; i++) begin feed_data[i] = 8'(8'h11 + i); feed_delay[i] = 0; end
        for (int i = 0; i < 18; i++) obs_bytes[i] = '0;
        rst = 1'b1; start = 1'b0; start_addr = '0; byte_count = '0;
        repeat (3) @(negedge clk);
        chk("rst_scl", scl, 1);
        chk("rst_sda", sda, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ack_error", ack_error, 0);
        chk("rst_data_ready", data_ready, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Ten data bytes 0x11..0x1A, always valid
        run_txn(8'h01, 10, -1, 0, 0);
        chk("t1_addr_byte", obs_bytes[0], 8'hD4);
        chk("t1_reg_byte", obs_bytes[1], 8'h01);
        chk("t1_last_byte", obs_bytes[11], 8'h1A);
        chk("t1_handshakes", hs_total - hs_base, 10);

        // Address NACK
        run_txn(8'h33, 4, 0, 0, 0);
        chk("t2_ack_error", ack_error, 1);

        // Second byte's data_valid delayed 20 cycles
        feed_data[0] = 8'hA5; feed_data[1] = 8'h3C; feed_data[2] = 8'hF0;
        feed_delay[1] = 20;
        run_txn(8'h20, 3, -1, 0, 1);
        chk("t3_byte2", obs_bytes[3], 8'h3C);
        feed_delay[1] = 0;

        // Pointer-only write
        run_txn(8'h07, 0, -1, 0, 0);
        chk("t4_reg_byte", obs_bytes[1], 8'h07);

        // Start while busy is ignored
        feed_data[0] = 8'h99;
        run_txn(8'h42, 1, -1, 1, 0);
        chk("t5_data_byte", obs_bytes[2], 8'h99);

        // NACK on second data byte: only two handshakes
        feed_data[0] = 8'h5A; feed_data[1] = 8'hC3;
        run_txn(8'h0F, 4, 3, 0, 0);

        // Reset during 5th bit of first data byte
        feed_data[0] = 8'hE7; feed_data[1] = 8'h18;
        setup_txn(8'h30, 4, -1);
        pulse_start(8'h30, 4);
        n = 0;
        while (!(byte_idx == 2 && bitcnt == 4 && !scl) && n < 3000) begin
            @(negedge clk); #2; n++;
        end
        chk("reach_5th_bit", int'(n < 3000), 1);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_scl", scl, 1);
        chk("mid_rst_sda", sda, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_ack_error", ack_error, 0);
        chk("mid_rst_data_ready", data_ready, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        feed_data[0] = 8'hC3; feed_data[1] = 8'h3C;
        run_txn(8'h10, 2, -1, 0, 0);
        chk("t6_byte3", obs_bytes[3], 8'h3C);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
